// File: rtl/div_issue_ctrl.sv
// Operand front-end for a registered single-cycle divider: buffers requests, issues them one at a time,
// screens zero divisors, and returns tagged quotients. Optional `DIVQ_STATS_EN adds handshake counters.
module div_issue_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic [WIDTH-1:0] div_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_q,
  output logic             out_dbz,
  output logic [TAG_W-1:0] out_tag
`ifdef DIVQ_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_dbz
`endif
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_OUT} state_t;

  logic [WIDTH-1:0] r_mem_a   [DEPTH];
  logic [WIDTH-1:0] r_mem_b   [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  logic [AW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic [TAG_W-1:0] r_tag_cnt;
  state_t           r_state;
  logic [WIDTH-1:0] r_div_a, r_div_b, r_out_q;
  logic             r_out_dbz, r_out_valid;
  logic [TAG_W-1:0] r_out_tag, r_job_tag;

  logic w_full, w_empty, w_push, w_pop, w_hs;
  logic [WIDTH-1:0] w_head_a, w_head_b;
  logic [TAG_W-1:0] w_head_tag;

  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_push     = in_valid & ~w_full;
  assign w_hs       = r_out_valid & out_ready;
  // A pop happens from IDLE, or back-to-back from OUT on the handshake edge.
  assign w_pop      = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_OUT) & w_hs));
  assign w_head_a   = r_mem_a[r_rptr];
  assign w_head_b   = r_mem_b[r_rptr];
  assign w_head_tag = r_mem_tag[r_rptr];

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem_a[r_wptr]   <= in_a;
      r_mem_b[r_wptr]   <= in_b;
      r_mem_tag[r_wptr] <= r_tag_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_tag_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wptr    <= r_wptr + AW'(1);
        r_tag_cnt <= r_tag_cnt + TAG_W'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_div_a     <= '0;
      r_div_b     <= '0;
      r_out_q     <= '0;
      r_out_dbz   <= 1'b0;
      r_out_tag   <= '0;
      r_out_valid <= 1'b0;
      r_job_tag   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_OUT: begin
          if (r_state == S_OUT && w_hs) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          if (w_pop) begin
            if (w_head_b != '0) begin
              r_div_a   <= w_head_a;
              r_div_b   <= w_head_b;
              r_job_tag <= w_head_tag;
              r_state   <= S_DRIVE;
            end else begin
              // Zero divisor is answered here; the divider inputs are left alone.
              r_out_q     <= '0;
              r_out_dbz   <= 1'b1;
              r_out_tag   <= w_head_tag;
              r_out_valid <= 1'b1;
              r_state     <= S_OUT;
            end
          end
        end
        S_DRIVE: r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_out_q     <= div_res;
          r_out_dbz   <= 1'b0;
          r_out_tag   <= r_job_tag;
          r_out_valid <= 1'b1;
          r_state     <= S_OUT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = ~w_full;
  assign div_a     = r_div_a;
  assign div_b     = r_div_b;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_dbz   = r_out_dbz;
  assign out_tag   = r_out_tag;

`ifdef DIVQ_STATS_EN
  logic [15:0] r_stat_ops, r_stat_dbz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ops <= '0;
      r_stat_dbz <= '0;
    end else if (w_hs) begin
      if (r_stat_ops != 16'hFFFF) r_stat_ops <= r_stat_ops + 16'd1;
      if (r_out_dbz && r_stat_dbz != 16'hFFFF) r_stat_dbz <= r_stat_dbz + 16'd1;
    end
  end

  assign stat_ops = r_stat_ops;
  assign stat_dbz = r_stat_dbz;
`else
  // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl: directed scenarios then random traffic against a
// transaction-level model of the request queue, issue latency and result ordering.
module tb_div_issue_ctrl;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b, div_a, div_b, div_res, out_q;
  logic             out_valid, out_ready, out_dbz;
  logic [TAG_W-1:0] out_tag;
`ifdef DIVQ_STATS_EN
  logic [15:0]      stat_ops, stat_dbz;
`endif

  always #5 clk = ~clk;

  div_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .div_a(div_a), .div_b(div_b), .div_res(div_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_dbz(out_dbz), .out_tag(out_tag)
`ifdef DIVQ_STATS_EN
    , .stat_ops(stat_ops), .stat_dbz(stat_dbz)
`endif
  );

  // Registered single-cycle divider the controller drives.
  always @(posedge clk)
    div_res <= (div_b != 0) ? div_a / div_b : '1;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t             mbuf[$];
  req_t             job;
  bit               have_job, exp_valid;
  int               wait_n;
  logic [TAG_W-1:0] mtag;
  logic [WIDTH-1:0] exp_div_a, exp_div_b;
  int               exp_ops, exp_dbz;
  int               n_checks = 0;
  int               n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock edge using the inputs presented before that edge.
  task automatic model_step();
    int pre;
    bit hs, idle;
    req_t r;
    if (rst) begin
      mbuf.delete();
      have_job = 0; exp_valid = 0; wait_n = 0; mtag = '0;
      exp_div_a = '0; exp_div_b = '0; exp_ops = 0; exp_dbz = 0;
      return;
    end
    pre  = mbuf.size();
    hs   = exp_valid && out_ready;
    idle = !have_job;
    if (have_job && !exp_valid) begin
      wait_n--;
      if (wait_n == 0) exp_valid = 1;
    end
    if (hs) begin
      $display("result tag=%0d a=%0d b=%0d q=%0d dbz=%0d", job.tag, job.a, job.b, out_q, out_dbz);
      have_job = 0; exp_valid = 0;
      if (exp_ops < 16'hFFFF) exp_ops++;
      if (job.b == 0 && exp_dbz < 16'hFFFF) exp_dbz++;
    end
    if ((idle || hs) && pre > 0) begin
      job = mbuf.pop_front();
      have_job = 1;
      if (job.b == 0) exp_valid = 1;
      else begin
        wait_n = 2;
        exp_div_a = job.a;
        exp_div_b = job.b;
      end
    end
    if (in_valid && pre < DEPTH) begin
      r.a = in_a; r.b = in_b; r.tag = mtag;
      mbuf.push_back(r);
      mtag = mtag + 1'b1;
    end
  endtask

  task automatic compare();
    chk("out_valid", out_valid, exp_valid);
    chk("in_ready", in_ready, mbuf.size() < DEPTH);
    chk("div_a", div_a, exp_div_a);
    chk("div_b", div_b, exp_div_b);
    if (exp_valid) begin
      chk("out_q", out_q, (job.b == 0) ? 0 : job.a / job.b);
      chk("out_dbz", out_dbz, job.b == 0);
      chk("out_tag", out_tag, job.tag);
    end
`ifdef DIVQ_STATS_EN
    chk("stat_ops", stat_ops, exp_ops);
    chk("stat_dbz", stat_dbz, exp_dbz);
`endif
  endtask

  task automatic cycle(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic ordy, input logic r);
    in_valid = v; in_a = a; in_b = b; out_ready = ordy; rst = r;
  endtask

  initial begin
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    cycle(2);
    drive(0, 0, 0, 1, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_dbz", out_dbz, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic divide: result visible three edges after acceptance.
    drive(1, 100, 7, 1, 0); cycle();
    drive(0, 0, 0, 1, 0);   cycle(3);
    chk("basic_q", out_q, 14);
    chk("basic_tag", out_tag, 0);
    cycle(2);

    // Max dividend, then a quotient of zero.
    drive(1, 16'hFFFF, 1, 1, 0); cycle();
    drive(0, 0, 0, 1, 0);        cycle(4);
    drive(1, 5, 9, 1, 0);        cycle();
    drive(0, 0, 0, 1, 0);        cycle(3);
    chk("small_q", out_q, 0);
    chk("small_tag", out_tag, 2);
    cycle(2);

    // Zero divisor: one-cycle latency, divider inputs untouched.
    drive(1, 1234, 0, 1, 0); cycle();
    drive(0, 0, 0, 1, 0);    cycle();
    chk("dbz_valid", out_valid, 1);
    chk("dbz_flag", out_dbz, 1);
    chk("dbz_div_b", div_b, 9);
    cycle(2);

    // Backpressure: only DEPTH+1 requests fit.
    for (int i = 0; i < 6; i++) begin
      drive(1, WIDTH'(50 + 10 * i), WIDTH'(i + 1), 0, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_accepted", mbuf.size() + have_job, DEPTH + 1);
    drive(0, 0, 0, 1, 0);
    cycle(20);

    // Reset while a job sits in SAMPLE with two requests queued.
    drive(1, 40, 5, 1, 0); cycle();
    drive(1, 41, 6, 1, 0); cycle();
    drive(1, 42, 7, 1, 0); cycle();
    drive(0, 0, 0, 1, 1);  cycle();
    drive(0, 0, 0, 1, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    drive(1, 9, 3, 1, 0); cycle();
    drive(0, 0, 0, 1, 0); cycle(3);
    chk("post_rst_q", out_q, 3);
    chk("post_rst_tag", out_tag, 0);
    cycle(2);

    // Random traffic with occasional zero divisors, stalls and resets.
    for (int i = 0; i < 1500; i++) begin
      logic [WIDTH-1:0] ra, rb;
      ra = WIDTH'($urandom);
      case ($urandom_range(0, 3))
        0: rb = '0;
        1: rb = WIDTH'($urandom_range(1, 15));
        default: rb = WIDTH'($urandom);
      endcase
      drive($urandom_range(0, 1), ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0);
      cycle();
    end
    drive(0, 0, 0, 1, 0);
    cycle(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
